// File: rtl/band_mix_if.sv
// Band playback / mix bus shared by the band sequencer and its environment.
// The master side is the sequencer; the slave side is the playback modules and the audio sink.
interface band_mix_if #(
   parameter int unsigned NUM_BANDS = 8,
   parameter int unsigned GAIN_W    = 8
) ();
   logic                          run;
   logic [NUM_BANDS-1:0]          band_mask;
   logic [NUM_BANDS*GAIN_W-1:0]   band_gain;
   logic [NUM_BANDS-1:0]          band_en;
   logic [NUM_BANDS*16-1:0]       band_data;
   logic [NUM_BANDS-1:0]          band_valid;
   logic signed [15:0]            mix_out;
   logic                          mix_valid;
   logic                          busy;
   logic                          overrun;
   logic                          timeout_err;

   modport master (
      input  run, band_mask, band_gain, band_data, band_valid,
      output band_en, mix_out, mix_valid, busy, overrun, timeout_err
   );

   modport slave (
      output run, band_mask, band_gain, band_data, band_valid,
      input  band_en, mix_out, mix_valid, busy, overrun, timeout_err
   );
endinterface

// File: rtl/band_mix_sequencer.sv
// Per-sample-tick band scheduler: strobes each unmasked band, applies its gain, emits one mixed sample.
// Define MIX_SAT_EN to clamp the mixed sample to 16-bit signed range instead of wrapping.
module band_mix_sequencer #(
   parameter int unsigned NUM_BANDS = 8,
   parameter int unsigned GAIN_W    = 8,
   parameter int unsigned TICK_DIV  = 100,
   parameter int unsigned TIMEOUT   = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   band_mix_if.master bus
);
   localparam int unsigned IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
   localparam int unsigned PROD_W = 16 + GAIN_W + 1;
   localparam int unsigned ACC_W  = PROD_W + $clog2(NUM_BANDS);
   localparam int unsigned CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned WCNT_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_ACC   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]                  r_state;
   logic [2:0]                  w_next_state;
   logic [CNT_W-1:0]            r_tick_cnt;
   logic                        w_tick;
   logic [NUM_BANDS-1:0]        r_mask;
   logic [NUM_BANDS*GAIN_W-1:0] r_gain;
   logic [IDX_W-1:0]            r_idx;
   logic [WCNT_W-1:0]           r_wait_cnt;
   logic signed [15:0]          r_sample;
   logic signed [ACC_W-1:0]     r_acc;
   logic [NUM_BANDS-1:0]        r_band_en;
   logic signed [15:0]          r_mix_out;
   logic                        r_mix_valid;
   logic                        r_busy;
   logic                        r_overrun;
   logic                        r_timeout_err;

   logic [IDX_W-1:0]            w_first_idx;
   logic [IDX_W-1:0]            w_next_idx;
   logic                        w_next_any;
   logic [IDX_W-1:0]            w_issue_idx;
   logic                        w_valid_sel;
   logic                        w_timeout_hit;
   logic [GAIN_W-1:0]           w_gain;
   logic signed [PROD_W-1:0]    w_prod;
   logic signed [15:0]          w_result;

   assign w_tick        = bus.run && (r_tick_cnt == CNT_W'(TICK_DIV - 1));
   assign w_valid_sel   = bus.band_valid[r_idx];
   assign w_timeout_hit = (r_wait_cnt == WCNT_W'(TIMEOUT - 1));
   assign w_gain        = r_gain[r_idx*GAIN_W +: GAIN_W];
   assign w_prod        = PROD_W'(r_sample) * PROD_W'($signed({1'b0, w_gain}));
   assign w_issue_idx   = (r_state == S_IDLE) ? w_first_idx : w_next_idx;

   // Lowest set bit of the live mask, and next set bit of the latched mask above r_idx
   always_comb begin
      w_first_idx = '0;
      w_next_idx  = '0;
      w_next_any  = 1'b0;
      for (int k = int'(NUM_BANDS) - 1; k >= 0; k--) begin
         if (bus.band_mask[k]) w_first_idx = IDX_W'(k);
         if (r_mask[k] && (IDX_W'(k) > r_idx)) begin
            w_next_idx = IDX_W'(k);
            w_next_any = 1'b1;
         end
      end
   end

`ifdef MIX_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);
   logic signed [ACC_W-1:0] w_shifted;
   assign w_shifted = r_acc >>> (GAIN_W - 1);
   always_comb begin
      w_result = w_shifted[15:0];
      if (w_shifted > SAT_MAX)      w_result = 16'sh7FFF;
      else if (w_shifted < SAT_MIN) w_result = 16'sh8000;
   end
`else
   assign w_result = 16'(r_acc >>> (GAIN_W - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (w_tick) w_next_state = (bus.band_mask == '0) ? S_DONE : S_ISSUE;
         S_ISSUE: w_next_state = S_WAIT;
         S_WAIT:  if (w_valid_sel || w_timeout_hit) w_next_state = S_ACC;
         S_ACC:   w_next_state = w_next_any ? S_ISSUE : S_DONE;
         S_DONE:  w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Sample tick divider, parked at zero while stopped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                     r_tick_cnt <= '0;
      else if (!bus.run || w_tick)                    r_tick_cnt <= '0;
      else                                            r_tick_cnt <= r_tick_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mask        <= '0;
         r_gain        <= '0;
         r_idx         <= '0;
         r_wait_cnt    <= '0;
         r_sample      <= '0;
         r_acc         <= '0;
         r_band_en     <= '0;
         r_mix_out     <= '0;
         r_mix_valid   <= 1'b0;
         r_busy        <= 1'b0;
         r_overrun     <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_mix_valid <= (r_state == S_DONE);
         r_busy      <= (w_next_state != S_IDLE);
         r_band_en   <= (w_next_state == S_ISSUE) ? (NUM_BANDS'(1) << w_issue_idx) : '0;
         if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: if (w_tick) begin
               r_mask <= bus.band_mask;
               r_gain <= bus.band_gain;
               r_acc  <= '0;
               r_idx  <= w_first_idx;
            end
            S_ISSUE: r_wait_cnt <= '0;
            S_WAIT: begin
               if (w_valid_sel) begin
                  r_sample <= bus.band_data[r_idx*16 +: 16];
               end else if (w_timeout_hit) begin
                  r_sample      <= '0;
                  r_timeout_err <= 1'b1;
               end else begin
                  r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
               end
            end
            S_ACC: begin
               r_acc <= r_acc + ACC_W'(w_prod);
               if (w_next_any) r_idx <= w_next_idx;
            end
            S_DONE: r_mix_out <= w_result;
            default: ;
         endcase
      end
   end

   assign bus.band_en     = r_band_en;
   assign bus.mix_out     = r_mix_out;
   assign bus.mix_valid   = r_mix_valid;
   assign bus.busy        = r_busy;
   assign bus.overrun     = r_overrun;
   assign bus.timeout_err = r_timeout_err;
endmodule

// File: tb/tb_band_mix_sequencer.sv
// Directed bench for band_mix_sequencer: a 100-cycle-tick instance for function/latency/reset,
// and a 20-cycle-tick instance for overrun behaviour.
module tb_band_mix_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   band_mix_if #(.NUM_BANDS(8), .GAIN_W(8)) m_if ();
   band_mix_if #(.NUM_BANDS(8), .GAIN_W(8)) f_if ();

   band_mix_sequencer #(.NUM_BANDS(8), .GAIN_W(8), .TICK_DIV(100), .TIMEOUT(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(m_if));
   band_mix_sequencer #(.NUM_BANDS(8), .GAIN_W(8), .TICK_DIV(20), .TIMEOUT(8)) u_fast (
      .clk(clk), .rst_n(rst_n), .bus(f_if));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int tick_cyc = 0;
   int m_cnt = 0;
   int en_log[$];
   int en_multi = 0;
   logic [7:0] m_resp = 8'hFF;
   logic [7:0] f_resp = 8'hFF;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] expv);
      checks++;
      if (obs !== expv) begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Playback modules answer one cycle after their enable
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_if.band_valid <= '0;
         f_if.band_valid <= '0;
      end else begin
         m_if.band_valid <= m_if.band_en & m_resp;
         f_if.band_valid <= f_if.band_en & f_resp;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference tick timing for the 100-cycle instance
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_cnt <= 0;
      else if (!m_if.run) m_cnt <= 0;
      else if (m_cnt == 99) begin
         m_cnt    <= 0;
         tick_cyc <= cyc;
      end else m_cnt <= m_cnt + 1;
   end

   always @(negedge clk) begin
      if (m_if.band_en != '0) begin
         bit found;
         found = 1'b0;
         if ($countones(m_if.band_en) != 1) en_multi++;
         for (int k = 0; k < 8; k++)
            if (m_if.band_en[k] && !found) begin
               en_log.push_back(k);
               found = 1'b1;
            end
      end
   end

   task automatic wait_mix(output int lat, output bit ok);
      ok  = 1'b0;
      lat = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (m_if.mix_valid) begin
            ok  = 1'b1;
            lat = cyc - tick_cyc;
            break;
         end
      end
   endtask

   task automatic wait_en(input int k, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (m_if.band_en[k]) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      int lat;
      bit ok;
      int e0;
      int frames;
      int exp_sat;
`ifdef MIX_SAT_EN
      exp_sat = 32767;
`else
      exp_sat = -22144;
`endif
      m_if.run = 1'b0; m_if.band_mask = '0; m_if.band_gain = '0; m_if.band_data = '0;
      f_if.run = 1'b0; f_if.band_mask = '0; f_if.band_gain = '0; f_if.band_data = '0;
      repeat (3) @(negedge clk);
      chk("rst_mix_out", m_if.mix_out, 16'sd0);
      chk("rst_mix_valid", m_if.mix_valid, 1'b0);
      chk("rst_band_en", m_if.band_en, 8'h00);
      chk("rst_busy", m_if.busy, 1'b0);
      chk("rst_overrun", m_if.overrun, 1'b0);
      chk("rst_timeout", m_if.timeout_err, 1'b0);

      // single band, unity gain
      rst_n = 1'b1;
      m_if.band_mask = 8'h01;
      m_if.band_gain[0 +: 8] = 8'h80;
      m_if.band_data[0 +: 16] = 16'sd1000;
      m_if.run = 1'b1;
      e0 = en_log.size();
      wait_mix(lat, ok);
      chk("t1_seen", ok, 1'b1);
      chk("t1_mix_out", m_if.mix_out, 16'sd1000);
      chk("t1_latency", lat, 5);
      chk("t1_en_count", en_log.size() - e0, 1);
      chk("t1_en_idx", en_log[e0], 0);
      @(negedge clk);
      chk("t1_pulse_width", m_if.mix_valid, 1'b0);
      chk("t1_hold", m_if.mix_out, 16'sd1000);

      // all bands full scale
      m_if.band_mask = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         m_if.band_gain[k*8 +: 8] = 8'h80;
         m_if.band_data[k*16 +: 16] = 16'sd30000;
      end
      e0 = en_log.size();
      wait_mix(lat, ok);
      chk("t2_seen", ok, 1'b1);
      chk("t2_mix_out", int'(m_if.mix_out), exp_sat);
      chk("t2_latency", lat, 26);
      chk("t2_en_count", en_log.size() - e0, 8);
      for (int k = 0; k < 8; k++) chk("t2_en_order", en_log[e0 + k], k);
      chk("t2_one_hot", en_multi, 0);

      // two bands, half gain on band 0; mask/gain changes mid-frame ignored
      m_if.band_mask = 8'h05;
      m_if.band_gain[0 +: 8] = 8'h40;
      m_if.band_gain[16 +: 8] = 8'h80;
      m_if.band_data[0 +: 16] = -16'sd2000;
      m_if.band_data[32 +: 16] = 16'sd300;
      e0 = en_log.size();
      wait_en(0, ok);
      chk("t3_en0_seen", ok, 1'b1);
      m_if.band_mask = 8'hFF;
      m_if.band_gain[0 +: 8] = 8'hFF;
      m_if.band_gain[16 +: 8] = 8'hFF;
      wait_mix(lat, ok);
      chk("t3_seen", ok, 1'b1);
      chk("t3_mix_out", int'(m_if.mix_out), -700);
      chk("t3_latency", lat, 8);
      chk("t3_en_count", en_log.size() - e0, 2);
      chk("t3_en_first", en_log[e0], 0);
      chk("t3_en_second", en_log[e0 + 1], 2);

      // band 2 never answers
      chk("t4_timeout_pre", m_if.timeout_err, 1'b0);
      m_if.band_mask = 8'h04;
      m_resp = 8'hFB;
      e0 = en_log.size();
      wait_mix(lat, ok);
      chk("t4_seen", ok, 1'b1);
      chk("t4_timeout", m_if.timeout_err, 1'b1);
      chk("t4_mix_out", m_if.mix_out, 16'sd0);
      chk("t4_en_idx", en_log[e0], 2);

      // sticky error survives a good frame
      m_resp = 8'hFF;
      m_if.band_mask = 8'h01;
      m_if.band_gain[0 +: 8] = 8'h80;
      m_if.band_data[0 +: 16] = 16'sd1000;
      wait_mix(lat, ok);
      chk("t4b_mix_out", m_if.mix_out, 16'sd1000);
      chk("t4b_sticky", m_if.timeout_err, 1'b1);

      // empty mask
      m_if.band_mask = 8'h00;
      e0 = en_log.size();
      wait_mix(lat, ok);
      chk("t5_seen", ok, 1'b1);
      chk("t5_mix_out", m_if.mix_out, 16'sd0);
      chk("t5_latency", lat, 2);
      chk("t5_en_count", en_log.size() - e0, 0);
      chk("t5_no_overrun", m_if.overrun, 1'b0);

      // reset while waiting on a band
      m_if.band_mask = 8'h04;
      m_resp = 8'hFB;
      wait_en(2, ok);
      chk("t6_en2_seen", ok, 1'b1);
      @(negedge clk);
      chk("t6_busy_in_wait", m_if.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_band_en", m_if.band_en, 8'h00);
      chk("t6_rst_busy", m_if.busy, 1'b0);
      chk("t6_rst_valid", m_if.mix_valid, 1'b0);
      chk("t6_rst_timeout", m_if.timeout_err, 1'b0);
      m_if.band_mask = 8'h01;
      m_resp = 8'hFF;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wait_mix(lat, ok);
      chk("t6_seen", ok, 1'b1);
      chk("t6_latency", lat, 5);
      chk("t6_mix_out", m_if.mix_out, 16'sd1000);
      chk("t6_timeout_clear", m_if.timeout_err, 1'b0);

      // fast ticks: every other tick lands mid-frame
      f_if.band_mask = 8'hFF;
      for (int k = 0; k < 8; k++) begin
         f_if.band_gain[k*8 +: 8] = 8'h80;
         f_if.band_data[k*16 +: 16] = 16'(100 * (k + 1));
      end
      f_if.run = 1'b1;
      frames = 0;
      for (int i = 0; i < 230; i++) begin
         @(negedge clk);
         if (i == 5) chk("f_overrun_early", f_if.overrun, 1'b0);
         if (f_if.mix_valid) begin
            frames++;
            chk("f_mix_out", f_if.mix_out, 16'sd3600);
         end
      end
      chk("f_overrun", f_if.overrun, 1'b1);
      chk("f_frames", frames, 5);
      chk("f_timeout", f_if.timeout_err, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
